// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse train generator.
package pulse_gen_pkg;

  localparam int DEFAULT_LEN_W = 8;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A requested high length of zero still produces a one-cycle pulse.
  function automatic logic [31:0] effective_high_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that times one HIGH or LOW phase.
// The count holds the number of remaining cycles minus one, so zero marks the
// final cycle of the phase.
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Drives N pulses of H high cycles separated by L low cycles on a registered
// output line, with a start/busy/done handshake and abort.
module pulse_train_generator
  import pulse_gen_pkg::*;
#(
  parameter int LEN_W = DEFAULT_LEN_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_idx
);

  state_t             state;
  logic [LEN_W-1:0]   high_lat;
  logic [LEN_W-1:0]   low_lat;
  logic [CNT_W-1:0]   num_lat;

  logic               cnt_load;
  logic               cnt_en;
  logic [LEN_W-1:0]   cnt_value;
  logic               cnt_zero;

  logic               accept;
  logic               last_pulse;
  logic [LEN_W-1:0]   eff_high_in;
  logic [LEN_W-1:0]   eff_high_lat;

  assign accept       = ((state == IDLE) || (state == DONE)) && start && !abort;
  assign last_pulse   = (pulse_idx == (num_lat - CNT_W'(1)));
  assign eff_high_in  = LEN_W'(effective_high_len(32'(high_len)));
  assign eff_high_lat = LEN_W'(effective_high_len(32'(high_lat)));

  phase_counter #(.W(LEN_W)) u_phase_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .en         (cnt_en),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

  // Load the phase counter on entry to every HIGH or LOW phase, else count down.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_value = '0;
    case (state)
      IDLE, DONE: begin
        if (accept && (num_pulses != '0)) begin
          cnt_load  = 1'b1;
          cnt_value = eff_high_in - LEN_W'(1);
        end
      end
      HIGH: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (!last_pulse) begin
          cnt_load  = 1'b1;
          cnt_value = (low_lat == '0) ? (eff_high_lat - LEN_W'(1))
                                      : (low_lat - LEN_W'(1));
        end
      end
      LOW: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else begin
          cnt_load  = 1'b1;
          cnt_value = eff_high_lat - LEN_W'(1);
        end
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  // Train sequencing FSM with operand latches, pulse index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
      high_lat  <= '0;
      low_lat   <= '0;
      num_lat   <= '0;
    end else if (abort && ((state == HIGH) || (state == LOW))) begin
      state     <= IDLE;
      out       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state     <= IDLE;
          out       <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          pulse_idx <= '0;
          if (accept) begin
            high_lat <= high_len;
            low_lat  <= low_len;
            num_lat  <= num_pulses;
            if (num_pulses != '0) begin
              state <= HIGH;
              out   <= 1'b1;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (cnt_zero) begin
            if (last_pulse) begin
              state     <= DONE;
              out       <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              pulse_idx <= '0;
            end else if (low_lat == '0) begin
              pulse_idx <= pulse_idx + CNT_W'(1);
            end else begin
              state <= LOW;
              out   <= 1'b0;
            end
          end
        end
        LOW: begin
          if (cnt_zero) begin
            state     <= HIGH;
            out       <= 1'b1;
            pulse_idx <= pulse_idx + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed self-checking bench for pulse_train_generator.
module tb_pulse_train_generator;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [7:0] num_pulses;
  logic       out;
  logic       busy;
  logic       done;
  logic [7:0] pulse_idx;

  int nAsserts = 0;
  int nFails   = 0;

  pulse_train_generator #(.LEN_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .pulse_idx  (pulse_idx)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic setOperands(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
    high_len   = h;
    low_len    = l;
    num_pulses = n;
  endtask

  // Drive start/abort for one rising edge, then return on the falling edge.
  task automatic applyStimulus(input logic st, input logic ab);
    start = st;
    abort = ab;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic eOut, input logic eBusy,
                             input logic eDone, input logic [7:0] eIdx);
    nAsserts++;
    assert (out === eOut) else begin
      nFails++;
      $error("[TB] FAIL %s.out: observed %0b expected %0b", tag, out, eOut);
    end
    nAsserts++;
    assert (busy === eBusy) else begin
      nFails++;
      $error("[TB] FAIL %s.busy: observed %0b expected %0b", tag, busy, eBusy);
    end
    nAsserts++;
    assert (done === eDone) else begin
      nFails++;
      $error("[TB] FAIL %s.done: observed %0b expected %0b", tag, done, eDone);
    end
    nAsserts++;
    assert (pulse_idx === eIdx) else begin
      nFails++;
      $error("[TB] FAIL %s.pulse_idx: observed %0d expected %0d", tag, pulse_idx, eIdx);
    end
  endtask

  // Expected waveforms, written out by hand.
  logic       trainOut  [12] = '{1,1,0,0,0,1,1,0,0,0,1,1};
  logic [7:0] trainIdx  [12] = '{0,0,0,0,0,1,1,1,1,1,2,2};
  logic       b2bStart  [8]  = '{1,1,1,1,1,0,0,0};
  logic       b2bOut    [8]  = '{1,0,1,0,1,0,1,0};
  logic       b2bBusy   [8]  = '{1,1,1,0,1,1,1,0};
  logic       b2bDone   [8]  = '{0,0,0,1,0,0,0,1};
  logic [7:0] b2bIdx    [8]  = '{0,0,1,0,0,0,1,0};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    setOperands(8'd0, 8'd0, 8'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_after_reset", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("[TB] single one-cycle pulse");
    setOperands(8'd1, 8'd1, 8'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("single_c1", 1'b1, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_c2", 1'b0, 1'b0, 1'b1, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_c3", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("[TB] train H=2 L=3 N=3, operands changed after start");
    setOperands(8'd2, 8'd3, 8'd3);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(i == 0, 1'b0);
      if (i == 0) setOperands(8'd7, 8'd7, 8'd9);
      checkOutput($sformatf("train_c%0d", i + 1), trainOut[i], 1'b1, 1'b0, trainIdx[i]);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("train_done", 1'b0, 1'b0, 1'b1, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("train_idle", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("[TB] N=0");
    setOperands(8'd3, 8'd3, 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("n0_c1", 1'b0, 1'b0, 1'b1, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("n0_c2", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("[TB] H=0 L=0 N=2 merges into one level");
    setOperands(8'd0, 8'd0, 8'd2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("h0l0_c1", 1'b1, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("h0l0_c2", 1'b1, 1'b1, 1'b0, 8'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("h0l0_c3", 1'b0, 1'b0, 1'b1, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("h0l0_c4", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("[TB] start held high, back-to-back trains");
    setOperands(8'd1, 8'd1, 8'd2);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(b2bStart[i], 1'b0);
      checkOutput($sformatf("b2b_c%0d", i + 1), b2bOut[i], b2bBusy[i], b2bDone[i], b2bIdx[i]);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("b2b_idle", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("[TB] abort in LOW gap");
    setOperands(8'd4, 8'd4, 8'd3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 0, 1'b0);
      checkOutput($sformatf("abort_high_c%0d", i + 1), 1'b1, 1'b1, 1'b0, 8'd0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_low_c5", 1'b0, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_c6", 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("abort_quiet_c%0d", i + 7), 1'b0, 1'b0, 1'b0, 8'd0);
    end
    setOperands(8'd1, 8'd1, 8'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("abort_beats_start", 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("fresh_c1", 1'b1, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("fresh_c2", 1'b0, 1'b0, 1'b1, 8'd0);

    $display("[TB] asynchronous reset mid-HIGH");
    setOperands(8'd4, 8'd1, 8'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_pre", 1'b1, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_async", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput($sformatf("rst_after_c%0d", i + 1), 1'b0, 1'b0, 1'b0, 8'd0);
    end
    setOperands(8'd2, 8'd1, 8'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst_restart_c1", 1'b1, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_restart_c2", 1'b1, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_restart_c3", 1'b0, 1'b0, 1'b1, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
